// File: rtl/fifo_reader.sv
// FIFO reader: pulls bytes from a 16x8 FIFO into a 2-entry skid buffer and
// streams them downstream over valid/ready, counting delivered bytes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no reads issued, buffer empty
// RUN   | reads issued whenever a skid slot is (or becomes) free
// DRAIN | reads stopped; buffered and in-flight bytes still delivered
module fifo_reader (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        fifo_empty,
   input  logic        fifo_wr,
   input  logic [7:0]  fifo_dout,
   output logic        fifo_rd,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_data,
   output logic [15:0] xfer_cnt,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  occ_q, occ_d;
   logic        inflight_q, inflight_d;
   logic [7:0]  buf0_q, buf0_d;
   logic [7:0]  buf1_q, buf1_d;
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   logic        pop;
   logic        accept;
   logic [1:0]  slots;

   always_comb begin
      slots   = occ_q + {1'b0, inflight_q};
      m_valid = rst && (occ_q != 2'd0);
      pop     = m_valid && m_ready;
      // A read may be issued into a full slot count only when a pop frees one this cycle.
      fifo_rd = rst && (state_q == RUN) && !fifo_empty &&
                ((slots < 2'd2) || ((slots == 2'd2) && pop));
      accept  = fifo_rd && !fifo_empty && !fifo_wr;

      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)
               state_d = RUN;
            else if ((occ_q == 2'd0) && !inflight_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      occ_d      = occ_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      inflight_d = accept;
      xfer_cnt_d = xfer_cnt_q + {15'd0, pop};

      // buf0 is always the oldest entry; capture lands behind whatever survives the pop.
      case ({inflight_q, pop})
         2'b10: begin
            if (occ_q == 2'd0)
               buf0_d = fifo_dout;
            else
               buf1_d = fifo_dout;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               buf0_d = fifo_dout;
            end else begin
               buf0_d = buf1_q;
               buf1_d = fifo_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= 8'h00;
         buf1_q     <= 8'h00;
         xfer_cnt_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign m_data   = buf0_q;
   assign xfer_cnt = xfer_cnt_q;
   assign busy     = rst && ((state_q == RUN) || (state_q == DRAIN));

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: per-cycle directed vectors against a behavioural FIFO,
// then a long streaming run to exercise xfer_cnt wrap-around.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        fifo_empty;
   logic        fifo_wr;
   logic [7:0]  fifo_dout = 8'h00;
   logic        fifo_rd;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic [15:0] xfer_cnt;
   logic        busy;

   logic [7:0]  fifo_wdata;
   logic        src_inf = 1'b0;
   logic [7:0]  src_byte = 8'h00;
   logic [7:0]  fm [0:255];
   logic [7:0]  fwp = 8'h00;
   logic [7:0]  frp = 8'h00;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fifo_reader dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_wr    (fifo_wr),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .xfer_cnt   (xfer_cnt),
      .busy       (busy)
   );

   // Behavioural FIFO: a write strobe blocks that cycle's read; read data appears next cycle.
   assign fifo_empty = src_inf ? 1'b0 : (fwp == frp);

   always @(posedge clk) begin
      if (fifo_wr) begin
         fm[fwp] <= fifo_wdata;
         fwp     <= fwp + 8'd1;
      end
      if (fifo_rd && !fifo_empty && !fifo_wr) begin
         if (src_inf) begin
            fifo_dout <= src_byte;
            src_byte  <= src_byte + 8'd1;
         end else begin
            fifo_dout <= fm[frp];
            frp       <= frp + 8'd1;
         end
      end
   end

   typedef struct {
      logic        rst;
      logic        en;
      logic        rdy;
      logic        wr;
      logic [7:0]  wd;
      logic        rd;
      logic        mv;
      logic        chk_md;
      logic [7:0]  md;
      logic        busy;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [$];

   task automatic v(input logic r, input logic e, input logic rdy, input logic wr,
                    input logic [7:0] wd, input logic rd, input logic mv, input logic chk,
                    input logic [7:0] md, input logic b, input logic [15:0] cnt);
      vec_t x;
      x.rst = r; x.en = e; x.rdy = rdy; x.wr = wr; x.wd = wd;
      x.rd = rd; x.mv = mv; x.chk_md = chk; x.md = md; x.busy = b; x.cnt = cnt;
      tbl.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   logic [31:0] got_w, exp_w;
   logic [15:0] exp_cnt;
   logic [7:0]  exp_byte;
   int          pops, cyc, derr;

   initial begin
      rst = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_wr = 1'b0; fifo_wdata = 8'h00;

      // reset held with en high; then write 11,22,33 and stream them out
      v(0,1,1,0,8'h00, 0,0,1,8'h00,0,16'd0);
      v(1,0,1,1,8'h11, 0,0,1,8'h00,0,16'd0);
      v(1,0,1,1,8'h22, 0,0,1,8'h00,0,16'd0);
      v(1,0,1,1,8'h33, 0,0,1,8'h00,0,16'd0);
      v(1,1,1,0,8'h00, 0,0,1,8'h00,0,16'd0);
      v(1,1,1,0,8'h00, 1,0,1,8'h00,1,16'd0);
      v(1,1,1,0,8'h00, 1,0,1,8'h00,1,16'd0);
      v(1,1,1,0,8'h00, 1,1,1,8'h11,1,16'd0);
      v(1,1,1,0,8'h00, 0,1,1,8'h22,1,16'd1);
      v(1,1,1,0,8'h00, 0,1,1,8'h33,1,16'd2);
      v(1,1,1,0,8'h00, 0,0,0,8'h00,1,16'd3);
      v(1,0,1,0,8'h00, 0,0,0,8'h00,1,16'd3);
      v(1,0,1,0,8'h00, 0,0,0,8'h00,1,16'd3);
      v(1,0,1,0,8'h00, 0,0,0,8'h00,0,16'd3);
      // backpressure: 4 bytes queued, only 2 reads while m_ready low
      v(1,0,0,1,8'h44, 0,0,0,8'h00,0,16'd3);
      v(1,0,0,1,8'h55, 0,0,0,8'h00,0,16'd3);
      v(1,0,0,1,8'h66, 0,0,0,8'h00,0,16'd3);
      v(1,0,0,1,8'h77, 0,0,0,8'h00,0,16'd3);
      v(1,1,0,0,8'h00, 0,0,0,8'h00,0,16'd3);
      v(1,1,0,0,8'h00, 1,0,0,8'h00,1,16'd3);
      v(1,1,0,0,8'h00, 1,0,0,8'h00,1,16'd3);
      v(1,1,0,0,8'h00, 0,1,1,8'h44,1,16'd3);
      v(1,1,0,0,8'h00, 0,1,1,8'h44,1,16'd3);
      v(1,1,0,0,8'h00, 0,1,1,8'h44,1,16'd3);
      v(1,1,1,0,8'h00, 1,1,1,8'h44,1,16'd3);
      v(1,1,1,0,8'h00, 1,1,1,8'h55,1,16'd4);
      v(1,1,1,0,8'h00, 0,1,1,8'h66,1,16'd5);
      v(1,1,1,0,8'h00, 0,1,1,8'h77,1,16'd6);
      v(1,1,1,0,8'h00, 0,0,0,8'h00,1,16'd7);
      // same-cycle write suppresses the read
      v(1,1,1,1,8'h88, 0,0,0,8'h00,1,16'd7);
      v(1,1,1,1,8'h99, 1,0,0,8'h00,1,16'd7);
      v(1,1,1,0,8'h00, 1,0,0,8'h00,1,16'd7);
      v(1,1,1,0,8'h00, 1,0,0,8'h00,1,16'd7);
      v(1,1,1,0,8'h00, 0,1,1,8'h88,1,16'd7);
      v(1,1,1,0,8'h00, 0,1,1,8'h99,1,16'd8);
      v(1,1,1,0,8'h00, 0,0,0,8'h00,1,16'd9);
      // en dropped with the buffer filling; DRAIN delivers AA,BB and leaves CC
      v(1,1,0,1,8'hAA, 0,0,0,8'h00,1,16'd9);
      v(1,1,0,1,8'hBB, 1,0,0,8'h00,1,16'd9);
      v(1,1,0,1,8'hCC, 1,0,0,8'h00,1,16'd9);
      v(1,1,0,0,8'h00, 1,0,0,8'h00,1,16'd9);
      v(1,1,0,0,8'h00, 1,0,0,8'h00,1,16'd9);
      v(1,0,0,0,8'h00, 0,1,1,8'hAA,1,16'd9);
      v(1,0,1,0,8'h00, 0,1,1,8'hAA,1,16'd9);
      v(1,0,1,0,8'h00, 0,1,1,8'hBB,1,16'd10);
      v(1,0,1,0,8'h00, 0,0,0,8'h00,1,16'd11);
      v(1,0,1,0,8'h00, 0,0,0,8'h00,0,16'd11);
      // reset with occ=1 and a read in flight; DD is discarded, EE follows
      v(1,0,0,1,8'hDD, 0,0,0,8'h00,0,16'd11);
      v(1,0,0,1,8'hEE, 0,0,0,8'h00,0,16'd11);
      v(1,1,0,0,8'h00, 0,0,0,8'h00,0,16'd11);
      v(1,1,0,0,8'h00, 1,0,0,8'h00,1,16'd11);
      v(1,1,0,0,8'h00, 1,0,0,8'h00,1,16'd11);
      v(0,1,1,0,8'h00, 0,0,0,8'h00,0,16'd11);
      v(1,1,1,0,8'h00, 0,0,1,8'h00,0,16'd0);
      v(1,1,1,0,8'h00, 1,0,0,8'h00,1,16'd0);
      v(1,1,1,0,8'h00, 0,0,0,8'h00,1,16'd0);
      v(1,1,1,0,8'h00, 0,1,1,8'hEE,1,16'd0);
      v(1,1,1,0,8'h00, 0,0,0,8'h00,1,16'd1);

      repeat (2) @(posedge clk);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; en = tbl[i].en; m_ready = tbl[i].rdy;
         fifo_wr = tbl[i].wr; fifo_wdata = tbl[i].wd;
         #1;
         got_w = {5'd0, fifo_rd, m_valid, busy, (tbl[i].chk_md ? m_data : 8'h00), xfer_cnt};
         exp_w = {5'd0, tbl[i].rd, tbl[i].mv, tbl[i].busy,
                  (tbl[i].chk_md ? tbl[i].md : 8'h00), tbl[i].cnt};
         check($sformatf("vec%0d{rd,mv,busy,md,cnt}", i), got_w, exp_w);
      end

      // Unlimited source at full throughput: 65536 pops take xfer_cnt from 1 round to 1.
      src_inf  = 1'b1;
      exp_cnt  = 16'd1;
      exp_byte = 8'h00;
      pops = 0; cyc = 0; derr = 0;
      while (pops < 65536 && cyc < 70000) begin
         @(negedge clk); #1;
         if (pops >= 65533)
            check($sformatf("wrap_cnt_pop%0d", pops), {16'd0, xfer_cnt}, {16'd0, exp_cnt});
         if (m_valid && m_ready) begin
            if (m_data !== exp_byte) derr++;
            exp_byte = exp_byte + 8'd1;
            exp_cnt  = exp_cnt + 16'd1;
            pops++;
         end
         cyc++;
      end
      check("stream_done_in_budget", {31'd0, (pops == 65536)}, 32'd1);
      check("stream_cycles_1_per_byte", {31'd0, (cyc <= 65540)}, 32'd1);
      check("stream_data_errors", derr, 32'd0);
      @(negedge clk); #1;
      check("wrap_cnt_final", {16'd0, xfer_cnt}, 32'h0000_0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-low reset; sampled on clk rising edge only.
REQ-004 en  in  1  permits new FIFO reads when high.
REQ-005 fifo_empty  in  1  empty flag from the 16x8 FIFO.
REQ-006 fifo_wr  in  1  write strobe presented to the same FIFO that cycle.
REQ-007 fifo_dout  in  8  FIFO read data, valid the cycle after an accepted read.
REQ-008 fifo_rd  out  1  read request to FIFO.
REQ-009 m_valid  out  1  downstream data valid.
REQ-010 m_ready  in  1  downstream ready.
REQ-011 m_data  out  8  downstream data.
REQ-012 xfer_cnt  out  16  count of bytes delivered downstream.
REQ-013 busy  out  1  high in RUN or DRAIN state.

Function
REQ-014 Accepted read SHALL be fifo_rd && !fifo_empty && !fifo_wr; a write in the same cycle suppresses the read, so a suppressed request SHALL NOT be counted.
REQ-015 inflight flag SHALL be set for exactly one cycle after an accepted read; in that cycle fifo_dout SHALL be captured into the skid buffer.
REQ-016 Skid buffer SHALL be 2 entries x 8 bits, in-order; occ in 0..2.
REQ-017 pop = m_valid && m_ready; m_valid = (occ != 0); m_data = oldest entry.
REQ-018 slots = occ + inflight; fifo_rd SHALL be high iff state==RUN && !fifo_empty && (slots < 2 || (slots == 2 && pop)).
REQ-019 fifo_rd SHALL be combinational from registered state and inputs; it SHALL never be high when occ + inflight - pop would exceed 1 at the next edge.
REQ-020 Capture and pop in the same cycle SHALL leave occ unchanged and preserve order.
REQ-021 Sustained throughput SHALL be 1 byte/cycle when en=1, FIFO non-empty, fifo_wr=0, m_ready=1.
REQ-022 Latency: accepted read at edge N -> byte on m_data with m_valid=1 after edge N+1.
REQ-023 m_data SHALL remain stable while m_valid && !m_ready.
REQ-024 xfer_cnt SHALL increment by 1 on each pop, wrapping 0xFFFF -> 0x0000.
REQ-025 States: IDLE, RUN, DRAIN.
REQ-026 IDLE -> RUN when en=1.
REQ-027 RUN -> DRAIN when en=0.
REQ-028 DRAIN -> IDLE when occ==0 && !inflight; DRAIN -> RUN when en=1.
REQ-029 In DRAIN, no reads SHALL be issued; buffered and in-flight bytes SHALL still be delivered.
REQ-030 fifo_empty high with slots<2 SHALL hold fifo_rd low with no state change.

Reset
REQ-031 On rst=0 at a clock edge: state=IDLE, occ=0, inflight=0, xfer_cnt=0.
REQ-032 While rst=0: fifo_rd=0, m_valid=0, busy=0.
REQ-033 m_data after reset SHALL be 0x00.
REQ-034 Reset mid-transfer SHALL discard buffered and in-flight bytes; no pop SHALL be counted in the reset cycle.
REQ-035 The first read after rst returns high SHALL be issued no earlier than the following edge.

Verification
REQ-036 Write 0x11,0x22,0x33 into FIFO, en=1, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, xfer_cnt=3, fifo_rd low once empty.
REQ-037 FIFO holds 4 bytes, m_ready=0 -> exactly 2 reads accepted, occ=2, m_data held at first byte; m_ready=1 -> remaining bytes delivered in order, none lost or duplicated.
REQ-038 fifo_rd high with fifo_wr=1 in the same cycle -> no capture the next cycle, byte delivered later exactly once.
REQ-039 en dropped with occ=2 -> state DRAIN, fifo_rd=0, 2 bytes delivered, then IDLE with busy=0.
REQ-040 rst=0 asserted with occ=1 and inflight=1 -> next cycle m_valid=0 and xfer_cnt=0; post-reset data starts from the next FIFO byte.
REQ-041 Preload xfer_cnt to 0xFFFE, perform 3 pops -> count reads 0x0001.
